muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the MIPS150 datapath. It sits beside the combinational ALU in the execute stage and implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers, plus MTHI/MTLO writes. It computes one bit per cycle under a start/busy/done handshake; the pipeline stalls on `busy` before MFHI/MFLO or a new mult/div.

## Interface

Parameters:
- `WIDTH`, 32, operand and HI/LO width; any value ≥ 4.
- `CNT_W`, $clog2(WIDTH+1), iteration counter width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request an operation; accepted only when `busy`=0.
- `op` in 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with `start`.
- `A` in WIDTH: rs operand (multiplicand / dividend); sampled with `start`.
- `B` in WIDTH: rt operand (multiplier / divisor); sampled with `start`.
- `hi_we` in 1: MTHI strobe.
- `lo_we` in 1: MTLO strobe.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: an operation is in flight.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation

- States: IDLE, RUN, FIX.
  - IDLE + `start` → RUN. Latch `op`, absolute values of operands for signed ops, both operand signs, and clear the counter.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter increments. After WIDTH steps → FIX.
  - FIX: apply sign correction, write HI/LO, pulse `done`, → IDLE.
- Multiply:
  - The 2·WIDTH-bit product goes to {HI,LO}.
  - Signed: negate the full 2·WIDTH product when the operand signs differ.
- Divide:
  - LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Signed most-negative / −1: LO = most-negative, HI = 0. No trap.
- Divide by zero (DIV or DIVU, B=0): LO = all ones, HI = A as sampled. Sign correction is bypassed.
- `hi`/`lo` hold their previous values for the whole operation; they change only at the FIX edge.
- `hi_we`/`lo_we`:
  - In IDLE, they write `wdata` at the next edge.
  - While `busy`=1, they are ignored; the operation completes unchanged.
  - If a write and `start` occur in the same IDLE cycle, the write takes effect, then the result overwrites it at FIX.
  - If `hi_we` and `lo_we` are asserted together, both registers take `wdata`.
- `start` while `busy`=1 is ignored (not queued).
- Reset, asynchronous and possibly mid-operation: state = IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, operand registers=0. The in-flight operation is discarded with no `done`.

## Timing

- `start` is accepted at edge k.
- `busy`=1 from after edge k until edge k+WIDTH+1.
- RUN steps occur on edges k+1 … k+WIDTH.
- FIX occurs on edge k+WIDTH+1: `hi`/`lo` update, `done`=1 for exactly that cycle, and `busy`=0 in the same cycle.
- Latency: WIDTH+1 cycles from acceptance to result (33 for WIDTH=32).
- Back-to-back: a new `start` is accepted in the `done` cycle, giving a throughput of one operation per WIDTH+1 cycles.
- `busy` and `done` are registered outputs with no combinational path from the inputs.
- `hi`/`lo` are registered.

## Test plan

- MULT A=0xFFFFFFFD (−3), B=5 → after 33 cycles `done`; hi=0xFFFFFFFF, lo=0xFFFFFFF1. `busy` high for exactly 33 cycles.
- MULTU A=B=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. A second `start` issued mid-run is ignored and produces no second `done`.
- DIV A=0xFFFFFFF9 (−7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU A=100, B=7 → lo=0x0000000E, hi=0x00000002.
- Boundaries:
  - DIVU A=0x12345678, B=0 → lo=0xFFFFFFFF, hi=0x12345678.
  - DIV A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI/MTLO and reset:
  - `hi_we` with wdata=0xA5A5A5A5 in IDLE → hi=0xA5A5A5A5 next cycle.
  - `lo_we` during `busy` → no effect.
  - `rst` pulse at cycle 10 of a DIVU → `busy`=0, hi=lo=0 immediately, no `done` follows.
  - A fresh operation then completes normally.
- Parameter sweep WIDTH=8: MULT 0x80×0x80 → hi=0x40, lo=0x00, latency 9. Randomised ops compared against a reference model for WIDTH=8 and 32.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit beside the execute-stage ALU.
//               It handles MULT/MULTU/DIV/DIVU into HI/LO and MTHI/MTLO
//               writes. Each operation takes one radix-2 step per cycle and
//               uses a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  localparam logic [1:0] c_OP_MULT  = 2'b00;

  localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] c_ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] c_ONES    = {WIDTH{1'b1}};
  localparam logic [2*WIDTH-1:0] c_ZERO2 = {(2*WIDTH){1'b0}};

  logic [1:0]         r_state;
  logic [1:0]         r_op;
  logic               r_sa;
  logic               r_sb;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand conditioning at acceptance. op[0]=0 marks the signed variants.
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;

  assign w_a_neg = ~op[0] & A[WIDTH-1];
  assign w_b_neg = ~op[0] & B[WIDTH-1];
  assign w_a_abs = w_a_neg ? (c_ZERO - A) : A;
  assign w_b_abs = w_b_neg ? (c_ZERO - B) : B;

  // Multiply step: r_acc = {partial product, remaining multiplier bits}.
  // The sum keeps its carry and shifts right into the upper half.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_a} : {1'b0, c_ZERO});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: r_acc = {partial remainder, dividend/quotient}.
  // The shifted remainder needs WIDTH+1 bits because it can reach 2*B-1.
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_ge       = ~w_diff[WIDTH];
  assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_ge};

  // Sign correction and result selection, used in FIX.
  logic               w_prod_neg;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_dsigned;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_divz;
  logic [WIDTH-1:0]   w_a_orig;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_prod_neg = (r_op == c_OP_MULT) & (r_sa ^ r_sb);
  assign w_prod     = w_prod_neg ? (c_ZERO2 - r_acc) : r_acc;
  assign w_dsigned  = ~r_op[0];
  assign w_quo      = r_acc[WIDTH-1:0];
  assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
  assign w_quo_fix  = (w_dsigned & (r_sa ^ r_sb)) ? (c_ZERO - w_quo) : w_quo;
  assign w_rem_fix  = (w_dsigned & r_sa) ? (c_ZERO - w_rem) : w_rem;
  assign w_divz     = (r_b == c_ZERO);
  // Negating |A| rebuilds A as sampled. The most-negative value maps to itself.
  assign w_a_orig   = r_sa ? (c_ZERO - r_a) : r_a;

  // Pick the HI/LO values that FIX writes for the latched operation.
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_op[1]) begin
      if (w_divz) begin
        w_res_hi = w_a_orig;
        w_res_lo = c_ONES;
      end else begin
        w_res_hi = w_rem_fix;
        w_res_lo = w_quo_fix;
      end
    end
  end

  // Control FSM and iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_op    <= 2'b00;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_a     <= c_ZERO;
      r_b     <= c_ZERO;
      r_acc   <= c_ZERO2;
      r_cnt   <= {CNT_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state <= c_RUN;
            r_busy  <= 1'b1;
            r_op    <= op;
            r_sa    <= w_a_neg;
            r_sb    <= w_b_neg;
            r_a     <= w_a_abs;
            r_b     <= w_b_abs;
            // Dividing loads the dividend. Multiplying loads the multiplier.
            r_acc   <= {c_ZERO, (op[1] ? w_a_abs : w_b_abs)};
            r_cnt   <= {CNT_W{1'b0}};
          end
        end
        c_RUN: begin
          r_acc <= r_op[1] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + c_CNT_ONE;
          if (r_cnt == c_LAST) begin
            r_state <= c_FIX;
          end
        end
        c_FIX: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // HI/LO registers: MTHI/MTLO writes land only in IDLE. The result lands at FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= c_ZERO;
      r_lo <= c_ZERO;
    end else if (r_state == c_FIX) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (r_state == c_IDLE) begin
      if (hi_we) begin
        r_hi <= wdata;
      end
      if (lo_we) begin
        r_lo <= wdata;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
//               Expected HI/LO values are queued as each operation is driven
//               and are popped when done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, start32, hiwe32, lowe32, busy32, done32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wd32, hi32, lo32;
  logic        rst8, start8, hiwe8, lowe8, busy8, done8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wd8, hi8, lo8;

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst32), .start(start32), .op(op32), .A(a32), .B(b32),
    .hi_we(hiwe32), .lo_we(lowe32), .wdata(wd32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32));

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .op(op8), .A(a8), .B(b8),
    .hi_we(hiwe8), .lo_we(lowe8), .wdata(wd8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8));

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_hi(input int w);
    return (w == 32) ? hi32 : {24'h0, hi8};
  endfunction
  function automatic logic [31:0] rd_lo(input int w);
    return (w == 32) ? lo32 : {24'h0, lo8};
  endfunction
  function automatic logic rd_busy(input int w);
    return (w == 32) ? busy32 : busy8;
  endfunction
  function automatic logic rd_done(input int w);
    return (w == 32) ? done32 : done8;
  endfunction

  task automatic set_start(input int w, input logic s, input logic [1:0] o,
                           input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      start32 = s; op32 = o; a32 = a; b32 = b;
    end else begin
      start8 = s; op8 = o; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  task automatic set_mt(input int w, input logic hwe, input logic lwe, input logic [31:0] wd);
    if (w == 32) begin
      hiwe32 = hwe; lowe32 = lwe; wd32 = wd;
    end else begin
      hiwe8 = hwe; lowe8 = lwe; wd8 = wd[7:0];
    end
  endtask

  // Reference model using wide signed/unsigned arithmetic (w <= 32).
  function automatic void model(input int w, input logic [1:0] op,
                                input longint unsigned a, input longint unsigned b,
                                output logic [31:0] ehi, output logic [31:0] elo);
    longint unsigned mask, p;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    sa = ((a >> (w - 1)) & 64'd1) != 0 ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb = ((b >> (w - 1)) & 64'd1) != 0 ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    ehi = '0;
    elo = '0;
    if (op[1] == 1'b0) begin
      if (op[0] == 1'b0) p = longint'(sa * sb);
      else               p = a * b;
      ehi = 32'((p >> w) & mask);
      elo = 32'(p & mask);
    end else if (b == 0) begin
      ehi = 32'(a);
      elo = 32'(mask);
    end else begin
      if (op[0] == 1'b0) begin
        q = sa / sb;
        r = sa % sb;
        elo = 32'(longint'(q) & longint'(mask));
        ehi = 32'(longint'(r) & longint'(mask));
      end else begin
        elo = 32'((a / b) & mask);
        ehi = 32'((a % b) & mask);
      end
    end
  endfunction

  // One operation: queue the expectation, start, wait for done (bounded),
  // then check latency, busy span, HI/LO hold and the result.
  // inj: 0 none, 1 extra start mid-run, 2 lo_we mid-run, 3 hi_we with start.
  task automatic run_op(input int w, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input string tag,
                        input int inj, input int inj_at);
    logic [31:0] prev_hi, prev_lo;
    res_t e;
    int cyc, nbusy, holdbad, extra;
    prev_hi = rd_hi(w);
    prev_lo = rd_lo(w);
    @(negedge clk);
    set_start(w, 1'b1, op, a, b);
    e.hi = ehi;
    e.lo = elo;
    sb_q.push_back(e);
    if (inj == 3) set_mt(w, 1'b1, 1'b0, 32'h0000_0077);
    @(posedge clk);
    #1;
    set_start(w, 1'b0, op, a, b);
    set_mt(w, 1'b0, 1'b0, 32'h0);
    nbusy = rd_busy(w) ? 1 : 0;
    if (inj == 3) begin
      check({tag, " mt+start hi"}, {32'h0, rd_hi(w)}, 64'h77 & ((w == 32) ? 64'hFFFF_FFFF : 64'hFF));
      prev_hi = rd_hi(w);
    end
    holdbad = 0;
    cyc = 0;
    while (!rd_done(w) && cyc < 100) begin
      @(negedge clk);
      if (inj == 1 && cyc == inj_at) set_start(w, 1'b1, ~op, ~a, b + 32'd1);
      if (inj == 2 && cyc == inj_at) set_mt(w, 1'b0, 1'b1, 32'h5A5A_5A5A);
      @(posedge clk);
      #1;
      set_start(w, 1'b0, op, a, b);
      set_mt(w, 1'b0, 1'b0, 32'h0);
      cyc++;
      if (!rd_done(w)) begin
        if (rd_busy(w)) nbusy++;
        if (rd_hi(w) !== prev_hi || rd_lo(w) !== prev_lo) holdbad++;
      end
    end
    check({tag, " latency"}, 64'(cyc), 64'(w + 1));
    check({tag, " busy cycles"}, 64'(nbusy), 64'(w + 1));
    check({tag, " busy at done"}, {63'h0, rd_busy(w)}, 64'h0);
    check({tag, " hi/lo held"}, 64'(holdbad), 64'h0);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 64'h1, 64'h0);
    end else begin
      e = sb_q.pop_front();
      check({tag, " hi"}, {32'h0, rd_hi(w)}, {32'h0, e.hi});
      check({tag, " lo"}, {32'h0, rd_lo(w)}, {32'h0, e.lo});
    end
    if (inj == 1) begin
      extra = 0;
      for (int i = 0; i < w + 5; i++) begin
        @(posedge clk);
        #1;
        if (rd_done(w)) extra++;
      end
      check({tag, " ignored start gives no done"}, 64'(extra), 64'h0);
    end
  endtask

  task automatic run_rand(input int w, input int n);
    logic [1:0] op;
    logic [31:0] a, b, ehi, elo, m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom & m;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom & m);
      model(w, op, longint'(a), longint'(b), ehi, elo);
      run_op(w, op, a, b, ehi, elo, $sformatf("rand%0d w%0d op%0d", i, w, op), 0, 0);
    end
  endtask

  initial begin
    int extra;
    rst32 = 1'b1; rst8 = 1'b1;
    set_start(32, 1'b0, 2'b00, 32'h0, 32'h0);
    set_start(8, 1'b0, 2'b00, 32'h0, 32'h0);
    set_mt(32, 1'b0, 1'b0, 32'h0);
    set_mt(8, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst32 = 1'b0; rst8 = 1'b0;
    #1;
    check("reset busy", {63'h0, busy32}, 64'h0);
    check("reset done", {63'h0, done32}, 64'h0);
    check("reset hi", {32'h0, hi32}, 64'h0);
    check("reset lo", {32'h0, lo32}, 64'h0);
    check("reset8 busy", {63'h0, busy8}, 64'h0);
    check("reset8 hi/lo", {48'h0, hi8, lo8}, 64'h0);

    // MTHI in IDLE, then MTHI+MTLO together.
    @(negedge clk);
    set_mt(32, 1'b1, 1'b0, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    set_mt(32, 1'b0, 1'b0, 32'h0);
    check("mthi hi", {32'h0, hi32}, 64'hA5A5_A5A5);
    check("mthi lo untouched", {32'h0, lo32}, 64'h0);
    @(negedge clk);
    set_mt(32, 1'b1, 1'b1, 32'h3C3C_3C3C);
    @(posedge clk);
    #1;
    set_mt(32, 1'b0, 1'b0, 32'h0);
    check("mthi+mtlo hi", {32'h0, hi32}, 64'h3C3C_3C3C);
    check("mthi+mtlo lo", {32'h0, lo32}, 64'h3C3C_3C3C);

    // Directed operations; consecutive calls start in the previous done cycle.
    run_op(32, 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "MULT -3*5", 0, 0);
    run_op(32, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "MULTU max*max", 1, 5);
    run_op(32, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "DIV -7/2", 2, 8);
    run_op(32, 2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, "DIVU 100/7", 3, 0);
    run_op(32, 2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, "DIVU by zero", 0, 0);
    run_op(32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "DIV mostneg/-1", 0, 0);
    run_op(32, 2'b10, 32'hFFFF_FF9C, 32'h0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, "DIV -100 by zero", 0, 0);

    // Asynchronous reset in the middle of a DIVU.
    @(negedge clk);
    set_start(32, 1'b1, 2'b11, 32'hDEAD_BEEF, 32'd3);
    @(posedge clk);
    #1;
    set_start(32, 1'b0, 2'b11, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    #2;
    rst32 = 1'b1;
    #1;
    check("midrst busy", {63'h0, busy32}, 64'h0);
    check("midrst done", {63'h0, done32}, 64'h0);
    check("midrst hi", {32'h0, hi32}, 64'h0);
    check("midrst lo", {32'h0, lo32}, 64'h0);
    @(negedge clk);
    rst32 = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done32) extra++;
    end
    check("midrst no done", 64'(extra), 64'h0);
    run_op(32, 2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, "post-reset DIVU", 0, 0);

    // Narrow instance.
    run_op(8, 2'b00, 32'h80, 32'h80, 32'h40, 32'h00, "w8 MULT 0x80*0x80", 0, 0);
    run_op(8, 2'b10, 32'h80, 32'hFF, 32'h00, 32'h80, "w8 DIV mostneg/-1", 0, 0);
    run_rand(8, 16);
    run_rand(32, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
